// File: rtl/word_serializer_if.sv
// Word-in / byte-out stream bundle for word_serializer.
// master drives words and byte backpressure; slave is the serializer.
interface word_serializer_if #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned NUM_BYTES  = 4
);
  localparam int unsigned LEN_W = $clog2(NUM_BYTES + 1);

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_BYTES*BYTE_WIDTH-1:0] in_word;
  logic [LEN_W-1:0]                in_len;
  logic                            out_valid;
  logic                            out_ready;
  logic [BYTE_WIDTH-1:0]           out_byte;
  logic                            out_last;
  logic                            busy;

  modport master (
    output in_valid, in_word, in_len, out_ready,
    input  in_ready, out_valid, out_byte, out_last, busy
  );

  modport slave (
    input  in_valid, in_word, in_len, out_ready,
    output in_ready, out_valid, out_byte, out_last, busy
  );
endinterface

// File: rtl/word_serializer.sv
// Serializes one packed word of NUM_BYTES bytes into a byte stream, with partial
// lengths, selectable byte order and zero-bubble word chaining.
module word_serializer #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned NUM_BYTES  = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  localparam int unsigned LEN_W     = $clog2(NUM_BYTES + 1)
) (
  input logic            clk,
  input logic            rst_n,
  word_serializer_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                                state_q, state_d;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0]  word_q, word_d;
  logic [LEN_W-1:0]                      len_q, len_d;
  logic [LEN_W-1:0]                      idx_q, idx_d;

  logic                  send;
  logic                  last;
  logic                  in_fire;
  logic                  out_fire;
  logic [LEN_W-1:0]      in_len_eff;
  logic [LEN_W-1:0]      sel_idx;
  logic [BYTE_WIDTH-1:0] sel_byte;

  assign send     = (state_q == StSend);
  assign last     = send && (idx_q == len_q - LEN_W'(1));
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = send && bus.out_ready;

  // Zero or out-of-range lengths mean a full word.
  assign in_len_eff = (bus.in_len == '0 || bus.in_len > LEN_W'(NUM_BYTES)) ?
                      LEN_W'(NUM_BYTES) : bus.in_len;

  always_comb begin
    sel_idx  = LSB_FIRST ? idx_q : (LEN_W'(NUM_BYTES - 1) - idx_q);
    sel_byte = '0;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (sel_idx == LEN_W'(k)) sel_byte = word_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (in_fire) begin
          word_d  = bus.in_word;
          len_d   = in_len_eff;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_fire) begin
          if (!last) begin
            idx_d = idx_q + LEN_W'(1);
          end else if (in_fire) begin
            word_d = bus.in_word;
            len_d  = in_len_eff;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  // The only combinational path: out_ready -> in_ready on the final byte.
  assign bus.in_ready  = !send || (last && bus.out_ready);
  assign bus.out_valid = send;
  assign bus.out_last  = last;
  assign bus.out_byte  = send ? sel_byte : '0;
  assign bus.busy      = send;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: an LSB-first and an MSB-first instance, a vector table,
// hand-written corner sequences and a per-instance expected-byte queue.
module tb_word_serializer;

  logic clk;
  logic rst_n;

  word_serializer_if #(.BYTE_WIDTH(8), .NUM_BYTES(4)) bus_l ();
  word_serializer_if #(.BYTE_WIDTH(8), .NUM_BYTES(4)) bus_m ();

  word_serializer #(.BYTE_WIDTH(8), .NUM_BYTES(4), .LSB_FIRST(1'b1)) u_dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  word_serializer #(.BYTE_WIDTH(8), .NUM_BYTES(4), .LSB_FIRST(1'b0)) u_dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Entries are {last, byte}; q_l serves the LSB-first instance, q_m the MSB-first one.
  logic [8:0] q_l[$];
  logic [8:0] q_m[$];

  // exp[8*i +: 8] is the i-th byte expected on the output.
  typedef struct packed {
    bit          sel;
    logic [31:0] word;
    logic [2:0]  len;
    logic [3:0]  n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input bit sel, input logic [7:0] b, input logic l);
    logic [8:0] e;
    if ((sel ? q_m.size() : q_l.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_byte: dut %0d got %h last %b expected nothing", sel, b, l);
    end else begin
      e = sel ? q_m.pop_front() : q_l.pop_front();
      chk(sel ? "m_out_byte" : "l_out_byte", {24'd0, b}, {24'd0, e[7:0]});
      chk(sel ? "m_out_last" : "l_out_last", {31'd0, l}, {31'd0, e[8]});
    end
  endtask

  function automatic logic get_in_ready(input bit sel);
    return sel ? bus_m.in_ready : bus_l.in_ready;
  endfunction

  function automatic logic get_out_valid(input bit sel);
    return sel ? bus_m.out_valid : bus_l.out_valid;
  endfunction

  task automatic push_exp(input bit sel, input logic [31:0] exp, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1), exp[8*i +: 8]};
      if (sel) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endtask

  task automatic drive_in(input bit sel, input logic v, input logic [31:0] w,
                          input logic [2:0] len);
    if (sel) begin
      bus_m.in_valid = v; bus_m.in_word = w; bus_m.in_len = len;
    end else begin
      bus_l.in_valid = v; bus_l.in_word = w; bus_l.in_len = len;
    end
  endtask

  // Returns at posedge+1 of the cycle that follows the input transfer.
  task automatic send_word(input bit sel, input logic [31:0] w, input logic [2:0] len,
                           input int n, input logic [31:0] exp);
    logic acc;
    push_exp(sel, exp, n);
    @(posedge clk); #1;
    drive_in(sel, 1'b1, w, len);
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (get_in_ready(sel)) acc = 1'b1;
    end
    chk("accept", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    // Scrambled inputs after the transfer must not disturb the held word.
    drive_in(sel, 1'b0, $urandom, 3'($urandom_range(0, 7)));
  endtask

  task automatic wait_drain(input bit sel);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if ((sel ? q_m.size() : q_l.size()) == 0 && !get_out_valid(sel)) done = 1'b1;
    end
    chk("drain", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_l_in_ready",  {31'd0, bus_l.in_ready},  32'd1);
    chk("rst_l_out_valid", {31'd0, bus_l.out_valid}, 32'd0);
    chk("rst_l_out_last",  {31'd0, bus_l.out_last},  32'd0);
    chk("rst_l_out_byte",  {24'd0, bus_l.out_byte},  32'd0);
    chk("rst_l_busy",      {31'd0, bus_l.busy},      32'd0);
    chk("rst_m_in_ready",  {31'd0, bus_m.in_ready},  32'd1);
    chk("rst_m_out_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("rst_m_out_last",  {31'd0, bus_m.out_last},  32'd0);
    chk("rst_m_out_byte",  {24'd0, bus_m.out_byte},  32'd0);
    chk("rst_m_busy",      {31'd0, bus_m.busy},      32'd0);
  endtask

  logic       held;
  logic [7:0] hb;
  logic       hl;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_in(1'b0, 1'b0, 32'd0, 3'd0);
    drive_in(1'b1, 1'b0, 32'd0, 3'd0);
    bus_l.out_ready = 1'b1;
    bus_m.out_ready = 1'b1;

    //               sel   word           len   n     exp
    vecs[0] = '{1'b0, 32'hDDCCBBAA, 3'd4, 4'd4, 32'hDDCCBBAA};
    vecs[1] = '{1'b1, 32'h11223344, 3'd2, 4'd2, 32'h00002211};
    vecs[2] = '{1'b0, 32'h04030201, 3'd0, 4'd4, 32'h04030201};
    vecs[3] = '{1'b0, 32'h87654321, 3'd7, 4'd4, 32'h87654321};
    vecs[4] = '{1'b0, 32'h556677E1, 3'd1, 4'd1, 32'h000000E1};
    vecs[5] = '{1'b1, 32'hA1B2C3D4, 3'd4, 4'd4, 32'hD4C3B2A1};
    vecs[6] = '{1'b1, 32'h01020304, 3'd3, 4'd3, 32'h00030201};
    vecs[7] = '{1'b1, 32'h0F1E2D3C, 3'd0, 4'd4, 32'h3C2D1E0F};

    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus_l.out_valid && bus_l.out_ready)
          check_out(1'b0, bus_l.out_byte, bus_l.out_last);
        if (rst_n && bus_m.out_valid && bus_m.out_ready)
          check_out(1'b1, bus_m.out_byte, bus_m.out_last);
      end
    join_none

    #22;
    chk_reset_vals();
    rst_n = 1'b1;

    // Full LSB-first word: in_ready low for three cycles, up with the last byte.
    send_word(1'b0, 32'hDDCCBBAA, 3'd4, 4, 32'hDDCCBBAA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_in_ready", {31'd0, bus_l.in_ready}, (i == 3) ? 32'd1 : 32'd0);
      chk("t1_busy", {31'd0, bus_l.busy}, 32'd1);
    end
    @(negedge clk);
    chk("t1_idle_busy", {31'd0, bus_l.busy}, 32'd0);
    chk("t1_idle_byte", {24'd0, bus_l.out_byte}, 32'd0);
    wait_drain(1'b0);

    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].sel, vecs[v].word, vecs[v].len, int'(vecs[v].n), vecs[v].exp);
      wait_drain(vecs[v].sel);
    end

    // Stall pattern 1,0,0,1: each stalled byte must hold until taken.
    bus_l.out_ready = 1'b0;
    send_word(1'b0, 32'h04030201, 3'd4, 4, 32'h04030201);
    held = 1'b0;
    hb   = 8'd0;
    hl   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus_l.out_ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
      if (held) begin
        chk("stall_valid", {31'd0, bus_l.out_valid}, 32'd1);
        chk("stall_byte",  {24'd0, bus_l.out_byte},  {24'd0, hb});
        chk("stall_last",  {31'd0, bus_l.out_last},  {31'd0, hl});
      end
      held = bus_l.out_valid && !bus_l.out_ready;
      hb   = bus_l.out_byte;
      hl   = bus_l.out_last;
    end
    bus_l.out_ready = 1'b1;
    wait_drain(1'b0);

    // Back-to-back words with in_valid held: no gap between A0 and B1.
    push_exp(1'b0, 32'h0000A0A1, 2);
    push_exp(1'b0, 32'h0000B0B1, 2);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b1, 32'h0000A0A1, 3'd2);
    @(negedge clk);
    chk("b2b_first_ready", {31'd0, bus_l.in_ready}, 32'd1);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b1, 32'h0000B0B1, 3'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, bus_l.out_valid}, 32'd1);
      chk("b2b_in_ready", {31'd0, bus_l.in_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 1) begin
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 32'h0, 3'd0);
      end
    end
    @(negedge clk);
    chk("b2b_end_valid", {31'd0, bus_l.out_valid}, 32'd0);
    chk("b2b_queue_empty", q_l.size(), 32'd0);

    // Reset mid-word after two bytes; the rest of the word is dropped.
    send_word(1'b0, 32'h44332211, 3'd4, 4, 32'h44332211);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    chk("rst_mid_dropped", q_l.size(), 32'd2);
    q_l.delete();
    @(negedge clk);
    chk("rst_hold_valid", {31'd0, bus_l.out_valid}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    send_word(1'b0, 32'hCAFEBABE, 3'd4, 4, 32'hCAFEBABE);
    wait_drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
